ahblite_sd_stream: RTL and testbench
====================================

# ahblite_sd_stream

AHB-lite slave that fronts the SD reader core with a programmable multi-slot playlist, a parametrised receive FIFO for `rd_data` words, and interrupt reporting. The CPU loads up to `NUM_SLOTS` start sector addresses, then issues start. The block sequences the reader through the slots in order and buffers each data word until the CPU pops it. It sits on the AHB matrix as a peripheral and drives the SD reader core's control inputs.

## Interface
- `DATA_W`, 16, reader word width (≤32).
- `FIFO_DEPTH`, 64, receive FIFO entries; power of two, 4..128.
- `NUM_SLOTS`, 4, address slots; power of two, 1..8.
- `DEFAULT_ADDR`, 34880, reset value of every slot and of `rd_addr_setting`.
- `RST_CYCLES`, 4, length of the `rd_addr_reset` pulse in HCLK cycles (≥1).

Ports:
- `HCLK`, in, 1, clock.
- `HRESETn`, in, 1, asynchronous active-low reset.
- `HSEL`, `HTRANS[1:0]`, `HWRITE`, `HREADY`, in, AHB control.
- `HADDR`, in, 32, AHB address; only `[5:2]` is decoded.
- `HSIZE[2:0]`, `HPROT[3:0]`, in, ignored.
- `HWDATA`, in, 32, write data.
- `HREADYOUT`, out, 1, constant 1.
- `HRESP`, out, 1, constant 0.
- `HRDATA`, out, 32, read data.
- `init_end`, in, 1, reader initialised.
- `rd_data_en`, in, 1, reader word valid.
- `rd_data`, in, DATA_W, reader word.
- `bin_read_over`, in, 1, single-cycle pulse marking the end of the current file.
- `read_frame_cnt`, in, 8, reader frame counter.
- `rd_addr_setting`, out, 32, start address presented to the reader.
- `rd_addr_reset`, out, 1, reader address-reload pulse.
- `rd_stop`, out, 1, reader stop.
- `rd_retro`, out, 1, reader retro (reverse) mode.
- `rd_en`, out, 1, reader enable.
- `addr_default`, out, 1, high while `rd_addr_setting == DEFAULT_ADDR`.
- `irq`, out, 1, level interrupt.

## Operation
**AHB protocol**
- The address phase is registered when `HSEL & HREADY & HTRANS[1]`: capture `HADDR[5:2]` and a write flag.
- Writes commit at the end of the following (data) cycle.
- `HRDATA` is combinational from the registered address.
- Unmapped offsets read 0 and ignore writes.

**Register map** (offset: content)
- 0x00 CTRL, RW:
  - b0 `enable`.
  - b1 `stop`, drives `rd_stop`.
  - b2 `retro`, drives `rd_retro`.
  - b3 `auto`, advance to the next slot on `bin_read_over`.
  - b4 `flush`, self-clearing, reads 0.
  - b5 `start`, self-clearing, reads 0.
- 0x04 STATUS, RO:
  - b0 `init_end`.
  - b1 empty.
  - b2 full.
  - b3 overflow (sticky).
  - b6:4 current slot.
  - b10:8 FSM state.
  - b23:16 FIFO level.
- 0x08 SLOT_SEL, RW: slot used by `start`; `log2(NUM_SLOTS)` bits, upper bits ignored.
- 0x0C FIFO_DATA, RO: zero-extended head word.
  - A read with FIFO non-empty pops one entry at the end of its data phase.
  - A read with FIFO empty returns 0 and does not pop.
- 0x10 IRQ_EN, RW, [2:0].
- 0x14 IRQ_STAT, write-1-to-clear:
  - b0 level ≥ THRESH (level-sensitive, cannot be cleared while true).
  - b1 overflow event.
  - b2 file done (`bin_read_over` seen).
- 0x18 THRESH, RW, 8 bits, reset `FIFO_DEPTH/2`.
- 0x1C FRAME_CNT, RO: `{24'b0, read_frame_cnt}`.
- 0x20 + 4·i: SLOT_ADDR[i], RW, for i < `NUM_SLOTS`.

**FIFO**
- Push on `rd_data_en` when the FIFO is not full, or when a pop occurs in the same cycle.
- A push attempted while full with no pop drops the word and sets overflow plus IRQ_STAT.b1.
- Flush zeroes the pointers and level; it does not clear overflow. Overflow is cleared only by a W1C of IRQ_STAT.b1.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap naturally; level is `log2(FIFO_DEPTH)+1` bits.

**FSM**
- IDLE → LOAD on `start`.
- LOAD (1 cycle): `rd_addr_setting <= SLOT_ADDR[SLOT_SEL]`, current slot `<= SLOT_SEL`; then → RST.
- RST: assert `rd_addr_reset` for `RST_CYCLES` cycles; then → RUN.
- RUN: `rd_en = enable & init_end & ~full`.
  - On `bin_read_over`: set IRQ_STAT.b2.
  - If `auto`: current slot `+1` (wraps to 0), load that slot's address, → RST.
  - Otherwise → DONE.
- DONE → LOAD on `start`.
- `start` in any state restarts from LOAD; flush is applied in the same cycle.
- `rd_en` is 0 outside RUN.

**IRQ**
- `irq = |(IRQ_STAT & IRQ_EN)`.

## Timing
- Reset values:
  - All outputs 0, except `rd_addr_setting = DEFAULT_ADDR` and `addr_default = 1`.
  - `HREADYOUT = 1`.
  - All slots `DEFAULT_ADDR`; CTRL 0; SLOT_SEL 0; IRQ_EN 0; IRQ_STAT 0; FIFO empty; FSM in IDLE.
- Write latency: a register value is visible on its outputs one cycle after the data phase.
- Start latency: `start` written in data cycle T gives LOAD at T+1, `rd_addr_reset` high during T+2 … T+1+`RST_CYCLES`, and RUN from T+2+`RST_CYCLES`.
- A word pushed in cycle N is readable from N+1. Level updates one cycle after a push or pop.
- Back-to-back FIFO_DATA reads pop one word per transfer.
- A W1C write in the same cycle as a new event keeps the event bit set (set wins).
- Asynchronous reset mid-transfer returns every register and output to its reset value immediately; the FIFO contents are discarded.

## Test plan
- Reset, then read every register → values as listed under reset; `addr_default = 1`; STATUS.b1 = 1.
- Write SLOT_ADDR[2] = 0x1000, SLOT_SEL = 2, CTRL = 0x21 → `rd_addr_setting = 0x1000`; `rd_addr_reset` high for exactly 4 cycles; `rd_en` rises when `init_end = 1`; `addr_default = 0`.
- Push 64 words 0x0001..0x0040 with no reads, then one more → full = 1, overflow = 1, IRQ_STAT.b1 = 1, `irq` high if IRQ_EN.b1 set; 64 pops return 0x0001..0x0040 in order; the next read returns 0 with no pop.
- In RUN with `auto = 1` from slot 3 of 4, pulse `bin_read_over` → current slot 0, SLOT_ADDR[0] loaded, a new `rd_addr_reset` pulse, IRQ_STAT.b2 set. Repeat with `auto = 0` → state DONE, `rd_en = 0`.
- Full FIFO with `rd_data_en` in the same cycle as a FIFO_DATA pop → word accepted, level stays 64, no overflow.
- Assert THRESH = 8 and push 8 words → IRQ_STAT.b0 = 1; a W1C of b0 has no effect; pop 1 → b0 = 0. Assert HRESETn low mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahblite_sd_stream.sv
// ahblite_sd_stream
// AHB-lite peripheral that drives the SD reader core through a playlist of
// start sectors and buffers the words it returns in a receive FIFO.
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL..HWDATA           AHB-lite slave inputs (HSIZE/HPROT unused)
//   HREADYOUT, HRESP       constant ready / OKAY
//   HRDATA                 read data, decoded from the registered address
//   init_end, rd_data_en,  reader status and data stream
//   rd_data, bin_read_over,
//   read_frame_cnt
//   rd_addr_setting,       reader control: start sector, reload pulse,
//   rd_addr_reset, rd_stop,stop, reverse mode, enable
//   rd_retro, rd_en
//   addr_default           high while the start sector equals DEFAULT_ADDR
//   irq                    level interrupt, |(IRQ_STAT & IRQ_EN)
module ahblite_sd_stream #(
    parameter int          DATA_W       = 16,
    parameter int          FIFO_DEPTH   = 64,
    parameter int          NUM_SLOTS    = 4,
    parameter logic [31:0] DEFAULT_ADDR = 32'd34880,
    parameter int          RST_CYCLES   = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    input  logic              init_end,
    input  logic              rd_data_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              bin_read_over,
    input  logic [7:0]        read_frame_cnt,
    output logic [31:0]       rd_addr_setting,
    output logic              rd_addr_reset,
    output logic              rd_stop,
    output logic              rd_retro,
    output logic              rd_en,
    output logic              addr_default,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(RST_CYCLES) + 1;

    localparam logic [3:0] OFF_CTRL     = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h1;
    localparam logic [3:0] OFF_SLOT_SEL = 4'h2;
    localparam logic [3:0] OFF_FIFO     = 4'h3;
    localparam logic [3:0] OFF_IRQ_EN   = 4'h4;
    localparam logic [3:0] OFF_IRQ_STAT = 4'h5;
    localparam logic [3:0] OFF_THRESH   = 4'h6;
    localparam logic [3:0] OFF_FRAME    = 4'h7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RST  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    logic              hvalid_r, hwrite_r;
    logic [3:0]        haddr_r;
    logic              wr_s, rd_s, ctrl_wr_s, start_s, flush_s, w1c_s;
    logic [3:0]        ctrl_r;
    logic [SW-1:0]     slot_sel_r, cur_slot_r, nxt_slot_s;
    logic [2:0]        irq_en_r, irq_stat_s;
    logic [7:0]        thresh_r, level8_s;
    logic [31:0]       slot_addr_r [NUM_SLOTS];
    logic [31:0]       load_addr_s, nxt_addr_s, slot_rd_s, rdata_s;
    logic              ovf_r, done_r, thr_hit_s;
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wptr_r, rptr_r;
    logic [LW-1:0]     level_r;
    logic              empty_s, full_s, push_s, pop_s, ovf_evt_s, done_evt_s;
    state_t            state_r;
    logic [CW-1:0]     rst_cnt_r;
    logic              rd_addr_reset_r;
    logic [31:0]       rd_addr_setting_r;
    logic              unused_s;

    assign unused_s = ^{HSIZE, HPROT, HADDR[31:6], HADDR[1:0], HTRANS[0]};

    assign wr_s       = hvalid_r & hwrite_r;
    assign rd_s       = hvalid_r & ~hwrite_r;
    assign ctrl_wr_s  = wr_s & (haddr_r == OFF_CTRL);
    assign start_s    = ctrl_wr_s & HWDATA[5];
    assign flush_s    = ctrl_wr_s & HWDATA[4];
    assign w1c_s      = wr_s & (haddr_r == OFF_IRQ_STAT);

    assign empty_s    = (level_r == LW'(0));
    assign full_s     = (level_r == LW'(FIFO_DEPTH));
    assign pop_s      = rd_s & (haddr_r == OFF_FIFO) & ~empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_s     = rd_data_en & (~full_s | pop_s);
    assign ovf_evt_s  = rd_data_en & full_s & ~pop_s;
    assign done_evt_s = (state_r == ST_RUN) & bin_read_over;

    assign level8_s   = 8'(level_r);
    assign thr_hit_s  = (level8_s >= thresh_r);
    assign irq_stat_s = {done_r, ovf_r, thr_hit_s};

    assign HREADYOUT       = 1'b1;
    assign HRESP           = 1'b0;
    assign HRDATA          = rdata_s;
    assign rd_addr_setting = rd_addr_setting_r;
    assign rd_addr_reset   = rd_addr_reset_r;
    assign rd_stop         = ctrl_r[1];
    assign rd_retro        = ctrl_r[2];
    assign rd_en           = (state_r == ST_RUN) & ctrl_r[0] & init_end & ~full_s;
    assign addr_default    = (rd_addr_setting_r == DEFAULT_ADDR);
    assign irq             = |(irq_stat_s & irq_en_r);

    // Slot lookups: selected slot, wrap-around successor, and bus readback.
    always_comb begin
        load_addr_s = DEFAULT_ADDR;
        nxt_addr_s  = DEFAULT_ADDR;
        slot_rd_s   = 32'd0;
        if (cur_slot_r == SW'(NUM_SLOTS - 1)) begin
            nxt_slot_s = SW'(0);
        end else begin
            nxt_slot_s = cur_slot_r + SW'(1);
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_addr_s = (slot_sel_r == SW'(i)) ? slot_addr_r[i] : load_addr_s;
            nxt_addr_s  = (nxt_slot_s == SW'(i)) ? slot_addr_r[i] : nxt_addr_s;
            slot_rd_s   = (haddr_r == 4'(8 + i)) ? slot_addr_r[i] : slot_rd_s;
        end
    end

    // Read data mux driven by the registered address-phase offset.
    always_comb begin
        rdata_s = 32'd0;
        case (haddr_r)
            OFF_CTRL:     rdata_s = 32'(ctrl_r);
            OFF_STATUS:   rdata_s = {8'd0, level8_s, 5'd0, state_r, 1'b0,
                                     3'(cur_slot_r), ovf_r, full_s, empty_s, init_end};
            OFF_SLOT_SEL: rdata_s = 32'(slot_sel_r);
            OFF_FIFO:     rdata_s = empty_s ? 32'd0 : 32'(mem_r[rptr_r]);
            OFF_IRQ_EN:   rdata_s = 32'(irq_en_r);
            OFF_IRQ_STAT: rdata_s = 32'(irq_stat_s);
            OFF_THRESH:   rdata_s = 32'(thresh_r);
            OFF_FRAME:    rdata_s = {24'd0, read_frame_cnt};
            default:      rdata_s = slot_rd_s;
        endcase
    end

    // AHB address phase capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hvalid_r <= 1'b0;
            hwrite_r <= 1'b0;
            haddr_r  <= 4'd0;
        end else if (HREADY) begin
            hvalid_r <= HSEL & HTRANS[1];
            hwrite_r <= HWRITE;
            haddr_r  <= HADDR[5:2];
        end
    end

    // Programmable registers, written at the end of the data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_r     <= 4'd0;
            slot_sel_r <= SW'(0);
            irq_en_r   <= 3'd0;
            thresh_r   <= 8'(FIFO_DEPTH / 2);
            for (int i = 0; i < NUM_SLOTS; i++) slot_addr_r[i] <= DEFAULT_ADDR;
        end else if (wr_s) begin
            case (haddr_r)
                OFF_CTRL:     ctrl_r     <= HWDATA[3:0];
                OFF_SLOT_SEL: slot_sel_r <= HWDATA[SW-1:0] & SW'(NUM_SLOTS - 1);
                OFF_IRQ_EN:   irq_en_r   <= HWDATA[2:0];
                OFF_THRESH:   thresh_r   <= HWDATA[7:0];
                default: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (haddr_r == 4'(8 + i)) slot_addr_r[i] <= HWDATA;
                    end
                end
            endcase
        end
    end

    // Sticky interrupt sources; a new event wins over a W1C in the same cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            ovf_r  <= ovf_evt_s  | (ovf_r  & ~(w1c_s & HWDATA[1]));
            done_r <= done_evt_s | (done_r & ~(w1c_s & HWDATA[2]));
        end
    end

    // FIFO pointers and fill level; flush overrides any push or pop.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_r  <= AW'(0);
            rptr_r  <= AW'(0);
            level_r <= LW'(0);
        end else if (flush_s) begin
            wptr_r  <= AW'(0);
            rptr_r  <= AW'(0);
            level_r <= LW'(0);
        end else begin
            if (push_s) wptr_r <= wptr_r + AW'(1);
            if (pop_s)  rptr_r <= rptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the level is zero.
    always_ff @(posedge HCLK) begin
        if (push_s) mem_r[wptr_r] <= rd_data;
    end

    // Playlist sequencer: load slot, pulse the reader reload, run, advance.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r           <= ST_IDLE;
            cur_slot_r        <= SW'(0);
            rst_cnt_r         <= CW'(0);
            rd_addr_reset_r   <= 1'b0;
            rd_addr_setting_r <= DEFAULT_ADDR;
        end else if (start_s) begin
            state_r         <= ST_LOAD;
            rd_addr_reset_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    rd_addr_setting_r <= load_addr_s;
                    cur_slot_r        <= slot_sel_r;
                    rst_cnt_r         <= CW'(0);
                    rd_addr_reset_r   <= 1'b1;
                    state_r           <= ST_RST;
                end
                ST_RST: begin
                    if (rst_cnt_r == CW'(RST_CYCLES - 1)) begin
                        rd_addr_reset_r <= 1'b0;
                        state_r         <= ST_RUN;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (bin_read_over) begin
                        if (ctrl_r[3]) begin
                            cur_slot_r        <= nxt_slot_s;
                            rd_addr_setting_r <= nxt_addr_s;
                            rst_cnt_r         <= CW'(0);
                            rd_addr_reset_r   <= 1'b1;
                            state_r           <= ST_RST;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_IDLE, ST_DONE: state_r <= state_r;
                default: begin
                    rd_addr_reset_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahblite_sd_stream.sv
// Self-checking bench for ahblite_sd_stream: directed sequence with random
// data, checked against a queue-based model of the FIFO and interrupt bits.
module tb_ahblite_sd_stream;

    localparam int          DEPTH = 64;
    localparam logic [31:0] DEF   = 32'd34880;

    logic        HCLK, HRESETn, HSEL, HWRITE, HREADY;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HREADYOUT, HRESP;
    logic        init_end, rd_data_en, bin_read_over;
    logic [15:0] rd_data;
    logic [7:0]  read_frame_cnt;
    logic [31:0] rd_addr_setting;
    logic        rd_addr_reset, rd_stop, rd_retro, rd_en, addr_default, irq;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] slot_m [4];
    logic [15:0] q [$];
    int          thr_m;
    logic        ovf_m, done_m;
    logic [31:0] rd;
    logic [15:0] w;
    logic [7:0]  rv, ev;

    ahblite_sd_stream dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HADDR(HADDR), .HSIZE(HSIZE),
        .HPROT(HPROT), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .init_end(init_end), .rd_data_en(rd_data_en),
        .rd_data(rd_data), .bin_read_over(bin_read_over),
        .read_frame_cnt(read_frame_cnt), .rd_addr_setting(rd_addr_setting),
        .rd_addr_reset(rd_addr_reset), .rd_stop(rd_stop), .rd_retro(rd_retro),
        .rd_en(rd_en), .addr_default(addr_default), .irq(irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    function automatic logic [31:0] exp_irq_stat();
        return {29'd0, done_m, ovf_m, (q.size() >= thr_m)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(negedge HCLK);
        idle_bus(); HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(negedge HCLK);
        d = HRDATA; idle_bus();
        @(negedge HCLK);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic push_word(input logic [15:0] v);
        rd_data_en = 1'b1; rd_data = v;
        @(negedge HCLK);
        rd_data_en = 1'b0;
        if (q.size() < DEPTH) q.push_back(v);
        else ovf_m = 1'b1;
    endtask

    // Back-to-back FIFO_DATA reads: one address phase per cycle.
    task automatic pop_burst(input int n);
        logic [31:0] exp;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0C;
        for (int i = 0; i < n; i++) begin
            @(negedge HCLK);
            exp = (q.size() > 0) ? 32'(q.pop_front()) : 32'd0;
            check("fifo_pop", HRDATA, exp);
            if (i == n - 1) idle_bus();
        end
        @(negedge HCLK);
    endtask

    task automatic sample8(output logic [7:0] r, output logic [7:0] e);
        for (int k = 0; k < 8; k++) begin
            @(negedge HCLK);
            r[k] = rd_addr_reset;
            e[k] = rd_en;
        end
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HADDR = 32'd0; HWDATA = 32'd0;
        HSIZE = 3'b010; HPROT = 4'd0; idle_bus();
        init_end = 1'b0; rd_data_en = 1'b0; rd_data = 16'd0; bin_read_over = 1'b0;
        read_frame_cnt = 8'($urandom_range(0, 255));
        thr_m = DEPTH / 2; ovf_m = 1'b0; done_m = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Reset values
        check("rst_addr_setting", rd_addr_setting, DEF);
        check("rst_addr_default", 32'(addr_default), 32'd1);
        check("rst_outputs", {26'd0, rd_addr_reset, rd_stop, rd_retro, rd_en, irq, HRESP}, 32'd0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        read_check("rst_ctrl", 32'h00, 32'd0);
        read_check("rst_status", 32'h04, 32'h2);
        read_check("rst_slot_sel", 32'h08, 32'd0);
        read_check("rst_fifo_empty", 32'h0C, 32'd0);
        read_check("rst_irq_en", 32'h10, 32'd0);
        read_check("rst_irq_stat", 32'h14, 32'd0);
        read_check("rst_thresh", 32'h18, 32'd32);
        read_check("frame_cnt", 32'h1C, {24'd0, read_frame_cnt});
        for (int i = 0; i < 4; i++) read_check("rst_slot", 32'h20 + 32'(4 * i), DEF);
        ahb_write(32'h30, 32'hDEAD_BEEF);
        read_check("unmapped", 32'h30, 32'd0);

        // Slot programming and start timing
        for (int i = 0; i < 4; i++) slot_m[i] = $urandom | 32'h8000_0000;
        slot_m[2] = 32'h0000_1000;
        for (int i = 0; i < 4; i++) ahb_write(32'h20 + 32'(4 * i), slot_m[i]);
        read_check("slot1_rb", 32'h24, slot_m[1]);
        init_end = 1'b1;
        ahb_write(32'h08, 32'h6);
        read_check("slot_sel_mask", 32'h08, 32'd2);
        ahb_write(32'h00, 32'h21);
        check("load_no_pulse", 32'(rd_addr_reset), 32'd0);
        sample8(rv, ev);
        check("start_rst_pulse", 32'(rv), 32'h0F);
        check("start_rd_en", 32'(ev), 32'hF0);
        check("start_addr", rd_addr_setting, 32'h1000);
        check("start_addr_default", 32'(addr_default), 32'd0);
        read_check("ctrl_self_clear", 32'h00, 32'h1);

        // Fill to full, overflow, ordered drain
        ahb_write(32'h10, 32'h2);
        for (int i = 1; i <= DEPTH; i++) push_word(16'(i));
        ahb_read(32'h04, rd);
        check("full_level", (rd >> 16) & 32'hFF, 32'(q.size()));
        check("full_bit", (rd >> 2) & 32'h1, 32'd1);
        check("full_rd_en", 32'(rd_en), 32'd0);
        check("full_irq_quiet", 32'(irq), 32'd0);
        push_word(16'h0041);
        ahb_read(32'h04, rd);
        check("ovf_status", (rd >> 3) & 32'h1, 32'(ovf_m));
        read_check("ovf_irq_stat", 32'h14, exp_irq_stat());
        check("ovf_irq", 32'(irq), 32'd1);
        pop_burst(DEPTH);
        read_check("empty_read", 32'h0C, 32'd0);
        ahb_read(32'h04, rd);
        check("drained_level", (rd >> 16) & 32'hFF, 32'd0);
        check("drained_ovf_sticky", (rd >> 3) & 32'h1, 32'd1);
        ahb_write(32'h14, 32'h2);
        ovf_m = 1'b0;
        read_check("ovf_w1c", 32'h14, exp_irq_stat());
        check("ovf_w1c_irq", 32'(irq), 32'd0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < DEPTH; i++) push_word(16'($urandom));
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0C;
        @(negedge HCLK);
        idle_bus();
        w = 16'($urandom);
        rd_data = w; rd_data_en = 1'b1;
        check("simul_pop", HRDATA, 32'(q.pop_front()));
        q.push_back(w);
        @(negedge HCLK);
        rd_data_en = 1'b0;
        ahb_read(32'h04, rd);
        check("simul_level", (rd >> 16) & 32'hFF, 32'(DEPTH));
        check("simul_no_ovf", (rd >> 3) & 32'h1, 32'd0);
        pop_burst(DEPTH);
        for (int i = 0; i < 5; i++) push_word(16'($urandom));
        ahb_write(32'h00, 32'h11);
        q.delete();
        ahb_read(32'h04, rd);
        check("flush_level", (rd >> 16) & 32'hFF, 32'd0);
        read_check("flush_ctrl", 32'h00, 32'h1);

        // Auto advance from the last slot wraps to slot 0
        ahb_write(32'h08, 32'h3);
        ahb_write(32'h00, 32'h29);
        sample8(rv, ev);
        check("auto_start_addr", rd_addr_setting, slot_m[3]);
        bin_read_over = 1'b1;
        @(posedge HCLK); #1;
        bin_read_over = 1'b0;
        sample8(rv, ev);
        done_m = 1'b1;
        check("auto_rst_pulse", 32'(rv), 32'h0F);
        check("auto_rd_en", 32'(ev), 32'hF0);
        check("auto_addr", rd_addr_setting, slot_m[0]);
        ahb_read(32'h04, rd);
        check("auto_cur_slot", (rd >> 4) & 32'h7, 32'd0);
        read_check("auto_irq_stat", 32'h14, exp_irq_stat());
        ahb_write(32'h14, 32'h4);
        done_m = 1'b0;
        ahb_write(32'h00, 32'h01);
        check("run_rd_en", 32'(rd_en), 32'd1);
        bin_read_over = 1'b1;
        @(posedge HCLK); #1;
        bin_read_over = 1'b0;
        sample8(rv, ev);
        done_m = 1'b1;
        check("done_no_pulse", 32'(rv), 32'h00);
        check("done_rd_en", 32'(ev), 32'h00);
        read_check("done_irq_stat", 32'h14, exp_irq_stat());
        check("done_irq_masked", 32'(irq), 32'd0);
        ahb_write(32'h10, 32'h4);
        check("done_irq", 32'(irq), 32'd1);

        // Threshold interrupt
        ahb_write(32'h14, 32'h7);
        done_m = 1'b0;
        ahb_write(32'h18, 32'd8);
        thr_m = 8;
        ahb_write(32'h10, 32'h1);
        for (int i = 0; i < 7; i++) push_word(16'($urandom));
        read_check("thr_below", 32'h14, exp_irq_stat());
        check("thr_below_irq", 32'(irq), 32'd0);
        push_word(16'($urandom));
        read_check("thr_hit", 32'h14, exp_irq_stat());
        check("thr_hit_irq", 32'(irq), 32'd1);
        ahb_write(32'h14, 32'h1);
        read_check("thr_w1c_ignored", 32'h14, exp_irq_stat());
        pop_burst(1);
        read_check("thr_after_pop", 32'h14, exp_irq_stat());

        // W1C colliding with a new file-done event: the event wins
        ahb_write(32'h00, 32'h21);
        repeat (8) @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h14;
        @(negedge HCLK);
        idle_bus(); HWDATA = 32'h4; bin_read_over = 1'b1;
        @(negedge HCLK);
        bin_read_over = 1'b0;
        done_m = 1'b1;
        read_check("w1c_set_wins", 32'h14, exp_irq_stat());

        // Asynchronous reset mid-transfer
        ahb_write(32'h10, 32'h4);
        ahb_write(32'h00, 32'h07);
        check("pre_rst_outputs", {28'd0, rd_stop, rd_retro, irq, addr_default}, 32'hE);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h20;
        #2 HRESETn = 1'b0;
        #1;
        check("arst_addr_setting", rd_addr_setting, DEF);
        check("arst_addr_default", 32'(addr_default), 32'd1);
        check("arst_outputs", {27'd0, rd_addr_reset, rd_stop, rd_retro, rd_en, irq}, 32'd0);
        @(negedge HCLK);
        idle_bus();
        HRESETn = 1'b1;
        q.delete(); ovf_m = 1'b0; done_m = 1'b0; thr_m = DEPTH / 2;
        @(negedge HCLK);
        read_check("arst_status", 32'h04, 32'h3);
        read_check("arst_ctrl", 32'h00, 32'd0);
        read_check("arst_irq_stat", 32'h14, exp_irq_stat());
        read_check("arst_slot2", 32'h28, DEF);
        read_check("arst_fifo", 32'h0C, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
